// File: rtl/wb_pkg.sv
// Shared Wishbone manager types and constants.
package wb_pkg;

  // Manager bus state: waiting for a request, or holding a cycle on the bus.
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_state_t;

  // Read data returned when a cycle is abandoned on timeout.
  localparam logic [31:0] WB_ERR_DATA = 32'hBAD0_BAD0;

  // Counter width for a given limit, never narrower than 8 bits.
  function automatic int unsigned wb_count_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// ACK_I wait counter: cleared when a cycle is accepted, counts BUS cycles
// without ACK_I, and flags the cycle in which the limit is reached.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = wb_count_width(LIMIT);

  logic [CW-1:0] count;

  // The increment about to happen would reach LIMIT: abandon on this edge.
  assign expired = count_en && (count == CW'(LIMIT - 1));

  // Wait counter; clear has priority so a new cycle always starts at zero.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wishbone_manager.sv
// Wishbone B4 classic single-cycle manager bridging a request handler to
// the bus. Optional ACK_I timeout is built when WB_TIMEOUT_EN is defined.
module wishbone_manager
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] adr_to_mem,
  input  logic [31:0] data_to_mem,
  input  logic [3:0]  sel_to_mem,
  output logic        mem_busy,
  output logic [31:0] data_from_mem,
  output logic        bus_error,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        CYC_O,
  output logic        STB_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  // A zero limit would expire before any subordinate could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wishbone_manager: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_t state;
  logic      accept;
  logic      timeout;

  assign accept   = (state == IDLE) && (mem_read || mem_write);
  assign mem_busy = (state == BUS);

`ifdef WB_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .nRst     (nRst),
    .clear    (accept),
    .count_en ((state == BUS) && !ACK_I),
    .expired  (timeout)
  );
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  // Bus FSM with registered Wishbone outputs and read-data capture.
  // NOTE: every register here sits on the async reset, so an abort mid-cycle
  // drops CYC_O/STB_O at once rather than waiting for the next edge.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      ADR_O         <= '0;
      DAT_O         <= '0;
      SEL_O         <= '0;
      WE_O          <= 1'b0;
      CYC_O         <= 1'b0;
      STB_O         <= 1'b0;
      data_from_mem <= '0;
`ifdef WB_TIMEOUT_EN
      bus_error     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUS;
            ADR_O <= adr_to_mem;
            DAT_O <= data_to_mem;
            SEL_O <= sel_to_mem;
            WE_O  <= mem_write;   // write wins when both requests are high
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
          end
        end
        BUS: begin
          if (ACK_I || timeout) begin
            state <= IDLE;
            ADR_O <= '0;
            DAT_O <= '0;
            SEL_O <= '0;
            WE_O  <= 1'b0;
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            if (!WE_O) begin
              data_from_mem <= ACK_I ? DAT_I : WB_ERR_DATA;
            end
`ifdef WB_TIMEOUT_EN
            if (!ACK_I) begin
              bus_error <= 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_manager.sv
// Directed, table-driven bench for wishbone_manager. Define WB_TIMEOUT_EN
// to also exercise the timeout path (built with TIMEOUT_CYCLES = 4).
module tb_wishbone_manager;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] adr_to_mem = '0;
  logic [31:0] data_to_mem = '0;
  logic [3:0]  sel_to_mem = '0;
  logic        mem_busy;
  logic [31:0] data_from_mem;
  logic        bus_error;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        WE_O;
  logic        CYC_O;
  logic        STB_O;
  logic [31:0] DAT_I = '0;
  logic        ACK_I = 1'b0;

  int passed = 0;
  int total  = 0;

  wishbone_manager #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .sel_to_mem    (sel_to_mem),
    .mem_busy      (mem_busy),
    .data_from_mem (data_from_mem),
    .bus_error     (bus_error),
    .ADR_O         (ADR_O),
    .DAT_O         (DAT_O),
    .SEL_O         (SEL_O),
    .WE_O          (WE_O),
    .CYC_O         (CYC_O),
    .STB_O         (STB_O),
    .DAT_I         (DAT_I),
    .ACK_I         (ACK_I)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_delay;   // BUS cycles before the one carrying ACK_I
    logic [31:0] dat_i;
    logic        exp_we;
    logic [31:0] exp_dfm;     // data_from_mem after completion
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, {31'd0, mem_busy}, 32'd0);
    check({tag, " cyc"},  {31'd0, CYC_O}, 32'd0);
    check({tag, " stb"},  {31'd0, STB_O}, 32'd0);
    check({tag, " we"},   {31'd0, WE_O}, 32'd0);
    check({tag, " adr"},  ADR_O, 32'd0);
    check({tag, " dat"},  DAT_O, 32'd0);
    check({tag, " sel"},  {28'd0, SEL_O}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hC, 1, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 4'hF, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0508, 32'h55AA_55AA, 4'h1, 0, 32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D};

    // Reset state
    #12;
    check_idle_outputs("reset");
    check("reset dfm", data_from_mem, 32'd0);
    check("reset err", {31'd0, bus_error}, 32'd0);
    nRst = 1'b1;
    tick();

    // No request: nothing starts
    for (int i = 0; i < 3; i++) begin
      tick();
      check("noreq busy", {31'd0, mem_busy}, 32'd0);
    end

    // Table of single transactions
    for (int v = 0; v < 5; v++) begin
      mem_read    = vecs[v].rd;
      mem_write   = vecs[v].wr;
      adr_to_mem  = vecs[v].adr;
      data_to_mem = vecs[v].dat;
      sel_to_mem  = vecs[v].sel;
      DAT_I       = ~vecs[v].dat_i;
      tick();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      adr_to_mem  = 32'hFFFF_FFFF;
      data_to_mem = 32'hFFFF_FFFF;
      sel_to_mem  = 4'h0;
      for (int c = 0; c <= vecs[v].ack_delay; c++) begin
        check($sformatf("v%0d c%0d busy", v, c), {31'd0, mem_busy}, 32'd1);
        check($sformatf("v%0d c%0d cyc", v, c), {31'd0, CYC_O & STB_O}, 32'd1);
        check($sformatf("v%0d c%0d adr", v, c), ADR_O, vecs[v].adr);
        check($sformatf("v%0d c%0d dat", v, c), DAT_O, vecs[v].dat);
        check($sformatf("v%0d c%0d sel", v, c), {28'd0, SEL_O}, {28'd0, vecs[v].sel});
        check($sformatf("v%0d c%0d we", v, c), {31'd0, WE_O}, {31'd0, vecs[v].exp_we});
        if (c == vecs[v].ack_delay) begin
          ACK_I = 1'b1;
          DAT_I = vecs[v].dat_i;
        end
        tick();
      end
      ACK_I = 1'b0;
      DAT_I = 32'h0;
      check_idle_outputs($sformatf("v%0d done", v));
      check($sformatf("v%0d dfm", v), data_from_mem, vecs[v].exp_dfm);
      check($sformatf("v%0d err", v), {31'd0, bus_error}, 32'd0);
      tick();
      check($sformatf("v%0d hold dfm", v), data_from_mem, vecs[v].exp_dfm);
    end

    // Requests during BUS ignored; held request accepted back-to-back
    mem_write = 1'b1; adr_to_mem = 32'h0000_0600; data_to_mem = 32'h600D_600D; sel_to_mem = 4'hF;
    tick();
    mem_read = 1'b1; adr_to_mem = 32'h0000_0700; data_to_mem = 32'h700D_700D;
    check("b2b first adr", ADR_O, 32'h0000_0600);
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    check("b2b gap busy", {31'd0, mem_busy}, 32'd0);
    tick();
    mem_read = 1'b0; mem_write = 1'b0;
    check("b2b second busy", {31'd0, mem_busy}, 32'd1);
    check("b2b second adr", ADR_O, 32'h0000_0700);
    check("b2b second we", {31'd0, WE_O}, 32'd1);
    ACK_I = 1'b1;
    tick();
    ACK_I = 1'b0;
    check("b2b end busy", {31'd0, mem_busy}, 32'd0);
    tick();
    check("b2b no extra", {31'd0, mem_busy}, 32'd0);

    // Reset two cycles into a read
    mem_read = 1'b1; adr_to_mem = 32'h0000_0800; sel_to_mem = 4'hF;
    tick();
    mem_read = 1'b0;
    tick();
    check("rst pre busy", {31'd0, mem_busy}, 32'd1);
    nRst = 1'b0;
    #1;
    check("rst cyc now", {31'd0, CYC_O}, 32'd0);
    check("rst stb now", {31'd0, STB_O}, 32'd0);
    check("rst busy now", {31'd0, mem_busy}, 32'd0);
    tick();
    tick();
    nRst = 1'b1;
    tick();
    check_idle_outputs("rst after");
    check("rst after dfm", data_from_mem, 32'd0);

`ifdef WB_TIMEOUT_EN
    // Unacknowledged read times out after TMO BUS cycles
    begin
      int n;
      mem_read = 1'b1; adr_to_mem = 32'h0000_0900;
      tick();
      mem_read = 1'b0;
      n = 0;
      while (mem_busy && n < 20) begin
        n++;
        tick();
      end
      check("tmo bus cycles", n, TMO);
      check("tmo err", {31'd0, bus_error}, 32'd1);
      check("tmo dfm", data_from_mem, 32'hBAD0_BAD0);
      check_idle_outputs("tmo idle");
      mem_write = 1'b1; adr_to_mem = 32'h0000_0A00;
      tick();
      mem_write = 1'b0;
      ACK_I = 1'b1;
      tick();
      ACK_I = 1'b0;
      check("tmo sticky", {31'd0, bus_error}, 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/wishbone_manager.md
WISHBONE_MANAGER -- requirements
Module: wishbone_manager

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, ACK_I wait limit in cycles (used only with WB_TIMEOUT_EN).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 nRst  in  1  reset, asynchronous, active-low.
REQ-004 mem_read  in  1  read request from request handler.
REQ-005 mem_write  in  1  write request from request handler.
REQ-006 adr_to_mem  in  32  request byte address.
REQ-007 data_to_mem  in  32  write data.
REQ-008 sel_to_mem  in  4  byte-lane select.
REQ-009 mem_busy  out  1  high while a transaction is outstanding.
REQ-010 data_from_mem  out  32  last completed read data.
REQ-011 bus_error  out  1  sticky timeout flag.
REQ-012 ADR_O, DAT_O (32), SEL_O (4), WE_O, CYC_O, STB_O  out  Wishbone B4 classic manager outputs.
REQ-013 DAT_I  in  32, ACK_I  in  1  Wishbone subordinate responses.

Function
REQ-014 Two states: IDLE, BUS; mem_busy SHALL equal (state == BUS), decoded directly from the state register.
REQ-015 Accept: at a rising edge in IDLE with mem_read|mem_write high, latch adr/data/sel, set WE = mem_write, go to BUS.
REQ-016 mem_read and mem_write both high: SHALL perform a write; read ignored.
REQ-017 In IDLE with neither request high, no transaction starts and mem_busy stays 0.
REQ-018 In BUS: CYC_O = STB_O = 1; ADR_O/DAT_O/SEL_O/WE_O hold latched values, stable until ACK_I.
REQ-019 In IDLE: CYC_O = STB_O = WE_O = 0, ADR_O = DAT_O = 0, SEL_O = 0.
REQ-020 At a rising edge in BUS with ACK_I = 1: return to IDLE; if read, data_from_mem <= DAT_I.
REQ-021 data_from_mem SHALL hold its value through writes and idle cycles until the next read completes.
REQ-022 Latency: mem_busy high from the cycle after accept until the cycle after ACK_I; with ACK_I in the first BUS cycle, mem_busy is high exactly 1 cycle.
REQ-023 Requests presented while in BUS are ignored; no queuing.
REQ-024 Back-to-back: in the first IDLE cycle after completion, a pending request is accepted on that edge.

Reset
REQ-025 nRst low SHALL immediately force IDLE, drop CYC_O/STB_O, and clear all outputs, latches, counter, and bus_error, including mid-transaction.

Configuration
REQ-026 WB_TIMEOUT_EN defined: an 8+ bit counter clears on accept and increments each BUS cycle without ACK_I.
REQ-027 With WB_TIMEOUT_EN, reaching TIMEOUT_CYCLES forces IDLE and sets bus_error (sticky until reset).
REQ-028 With WB_TIMEOUT_EN, a timeout on a read loads data_from_mem with 32'hBAD0_BAD0.
REQ-029 WB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; bus_error tied 0.

Structure
REQ-030 Shared package wb_pkg SHALL hold the wb_state_t enum (IDLE, BUS) and constant WB_ERR_DATA = 32'hBAD0_BAD0.
REQ-031 Timeout counter SHALL be sub-module wb_timeout_counter (inputs clear, count_en; output expired), instantiated only under WB_TIMEOUT_EN.

Verification
REQ-032 Read adr 0x0000_0100, ACK_I 1st BUS cycle, DAT_I 0xDEAD_BEEF -> CYC/STB high 1 cycle, mem_busy 1 cycle, then data_from_mem = 0xDEAD_BEEF.
REQ-033 Write adr 0x0000_0200, data 0x1234_5678, sel 4'b0011, ACK_I after 3 cycles -> WE_O = 1, outputs stable 3 cycles, mem_busy 4 cycles, data_from_mem unchanged.
REQ-034 mem_read = mem_write = 1 -> write cycle (WE_O = 1); second request during BUS produces no extra transaction.
REQ-035 nRst low 2 cycles into BUS -> CYC_O/STB_O/mem_busy fall immediately; after release, IDLE with all outputs 0.
REQ-036 WB_TIMEOUT_EN, TIMEOUT_CYCLES = 4, read never ACKed -> IDLE after 4 BUS cycles, bus_error = 1, data_from_mem = 0xBAD0_BAD0.
